uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial UART transmitter, directly downstream of the baud-rate tick generator; consumes its one-cycle `sample_tick` (one tick per bit period).
- Accepts one parallel byte per request via a start/busy/done handshake.
- Serialises the byte LSB-first as start, data, optional parity and stop bits on `tx`.
- Feeds the FPGA UART TX pin that returns AES results to the host PC.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8).
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  FPGA system clock.
- rst  input  1  synchronous, active-high reset.
- sample_tick  input  1  one-clk pulse per bit period from the baud generator.
- tx_start  input  1  request to send tx_data; sampled every clk.
- tx_data  input  DATA_BITS  byte to send; sampled only in the accepting cycle.
- tx  output  1  serial line, idle high; registered.
- tx_busy  output  1  high while a frame is in progress; registered.
- tx_done  output  1  one-clk pulse when the last stop bit has completed; registered.

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (rst).
- Reset (any cycle, including mid-frame): next edge gives tx=1, tx_busy=0, tx_done=0, state IDLE, shift register and counters cleared. A partial frame is abandoned; the line is simply held high.
- States: IDLE, SYNC, START, DATA, PARITY, STOP. All transitions below except IDLE->SYNC occur only on a clk edge where sample_tick=1.
- IDLE: tx=1. If tx_start=1:
  - latch tx_data into the shift register;
  - clear the parity accumulator;
  - go to SYNC with tx_busy=1 from the next cycle.
- SYNC: tx=1. Waits for the first tick so every bit lasts exactly one full tick period. On tick: tx<=0, go to START.
- START: on tick: tx<=shift[0], bit_idx<=0, parity accumulator ^= shift[0], go to DATA.
- DATA on tick:
  - if bit_idx < DATA_BITS-1: shift right, tx<=next bit, bit_idx++, accumulate parity;
  - else if PARITY_EN: tx<=accumulated parity ^ PARITY_ODD, go to PARITY;
  - else: tx<=1, stop_cnt<=0, go to STOP.
- PARITY: on tick: tx<=1, stop_cnt<=0, go to STOP.
- STOP: tx=1. On tick:
  - if stop_cnt==STOP_BITS-1: go to IDLE, tx_busy<=0, tx_done<=1 for exactly one clk;
  - else stop_cnt++.
- Frame length after SYNC: 1 + DATA_BITS + PARITY_EN + STOP_BITS tick periods. Each bit holds for exactly one tick period.
- Latency: from tx_start acceptance, the start-bit falling edge appears one clk after the first subsequent tick.
- Busy handling: tx_start while tx_busy=1 is ignored (no queuing); tx_data changes during a frame have no effect.
- Back-to-back: tx_start asserted in the same cycle tx_done is high is accepted, because the state is already IDLE. Stop-bit width is unaffected, since the new frame waits in SYNC for the next tick.
- sample_tick asserted in the same cycle as acceptance in IDLE is not used. SYNC waits for the following tick.
- Counter widths: bit_idx is 3 bits; stop_cnt is 1 bit.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams (3-bit);
  - default BAUD_DIV/counter-width constants for 9600 baud at 50 MHz;
  - frame-format defaults.
- No sub-module inside uart_tx. At the top level it is instantiated beside the baud tick generator; the generator's sample_tick connects directly to this block.

Test Plan:
- Drive sample_tick every 4 clks; PARITY_EN=0, STOP_BITS=1; pulse tx_start with 8'hA5. tx must show, 4 clks each: 0,1,0,1,0,0,1,0,1, then 1. tx_done pulses once at the end; tx_busy is high from the clk after acceptance until tx_done.
- Set PARITY_EN=1, PARITY_ODD=0, send 8'hA5: the parity bit is 0. With PARITY_ODD=1 the parity bit is 1. Also send 8'h01 with even parity: the parity bit is 1.
- Set STOP_BITS=2, send 8'h00: 8 low data bits, then 2 high tick periods, then tx_done. tx_start pulsed during the frame with 8'hFF produces no second frame.
- Back-to-back: hold tx_start=1 with 8'h55 then 8'hAA across tx_done. The second frame starts at the first tick after acceptance; tx stays high, with no glitch, between the frames.
- Assert rst during data bit 3 of 8'hF0: the next clk gives tx=1, busy=0, done=0. After rst drops, a fresh 8'h3C is transmitted correctly.
- Idle check: 100 ticks with no tx_start give tx=1, busy=0, done never asserted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud-rate constants and frame defaults.
// Imported by the transmitter and by its sibling baud tick generator.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SYNC   = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_STOP   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_SYNC   = ST_SYNC,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } tx_state_e;

    // 9600 baud from a 50 MHz system clock
    localparam int CLK_HZ     = 50_000_000;
    localparam int BAUD_RATE  = 9_600;
    localparam int BAUD_DIV   = CLK_HZ / BAUD_RATE;
    localparam int BAUD_CNT_W = $clog2(BAUD_DIV);

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_PARITY_EN  = 0;
    localparam int DEF_PARITY_ODD = 0;
    localparam int DEF_STOP_BITS  = 1;

    // Transmitted parity bit from the running XOR of the data bits
    function automatic logic parity_out(input logic acc, input logic odd);
        return acc ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: serialises one word per start/busy/done handshake, LSB first,
// advancing one bit per sample_tick from the baud generator.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int PARITY_EN  = DEF_PARITY_EN,
    parameter int PARITY_ODD = DEF_PARITY_ODD,
    parameter int STOP_BITS  = DEF_STOP_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic       ODD_SENSE = 1'(PARITY_ODD);

    tx_state_e            state_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [2:0]           bit_idx_r;
    logic                 stop_cnt_r;
    logic                 parity_r;
    logic                 tx_r;
    logic                 busy_r;
    logic                 done_r;

    // Frame sequencer; shift_r[0] always holds the bit currently on the line
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            shift_r    <= '0;
            bit_idx_r  <= 3'd0;
            stop_cnt_r <= 1'b0;
            parity_r   <= 1'b0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    tx_r <= 1'b1;
                    if (tx_start) begin
                        shift_r  <= tx_data;
                        parity_r <= 1'b0;
                        busy_r   <= 1'b1;
                        state_r  <= S_SYNC;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                S_SYNC: begin
                    if (sample_tick) begin
                        tx_r    <= 1'b0;
                        state_r <= S_START;
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
                S_START: begin
                    if (sample_tick) begin
                        tx_r      <= shift_r[0];
                        bit_idx_r <= 3'd0;
                        parity_r  <= parity_r ^ shift_r[0];
                        state_r   <= S_DATA;
                    end else begin
                        tx_r <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (sample_tick) begin
                        if (bit_idx_r < LAST_IDX) begin
                            shift_r   <= shift_r >> 1;
                            tx_r      <= shift_r[1];
                            bit_idx_r <= bit_idx_r + 3'd1;
                            parity_r  <= parity_r ^ shift_r[1];
                        end else if (PARITY_EN != 0) begin
                            tx_r    <= parity_out(parity_r, ODD_SENSE);
                            state_r <= S_PARITY;
                        end else begin
                            tx_r       <= 1'b1;
                            stop_cnt_r <= 1'b0;
                            state_r    <= S_STOP;
                        end
                    end else begin
                        tx_r <= shift_r[0];
                    end
                end
                S_PARITY: begin
                    if (sample_tick) begin
                        tx_r       <= 1'b1;
                        stop_cnt_r <= 1'b0;
                        state_r    <= S_STOP;
                    end else begin
                        tx_r <= tx_r;
                    end
                end
                S_STOP: begin
                    tx_r <= 1'b1;
                    if (sample_tick) begin
                        if (stop_cnt_r == LAST_STOP) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= S_IDLE;
                        end else begin
                            stop_cnt_r <= stop_cnt_r + 1'b1;
                        end
                    end else begin
                        stop_cnt_r <= stop_cnt_r;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign tx      = tx_r;
    assign tx_busy = busy_r;
    assign tx_done = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four parameterisations share one clock, reset and
// a sample_tick every 4 clks; each frame is checked bit-by-bit, clock-by-clock.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_tick = 1'b0;
    logic [1:0] tick_div = 2'd0;
    logic [3:0] start = 4'b0000;
    logic [7:0] data [4];
    logic [3:0] tx_o;
    logic [3:0] busy_o;
    logic [3:0] done_o;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          sel;
        logic [7:0]  data;
        logic [11:0] frame;   // bit i = i-th bit on the line, start bit first
        int          nbits;
        bit          poke;
    } vec_t;

    vec_t vecs [8];

    // dut0: 8N1, dut1: 8E1, dut2: 8O1, dut3: 8N2
    uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .tx_start(start[0]),
        .tx_data(data[0]), .tx(tx_o[0]), .tx_busy(busy_o[0]), .tx_done(done_o[0]));
    uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .tx_start(start[1]),
        .tx_data(data[1]), .tx(tx_o[1]), .tx_busy(busy_o[1]), .tx_done(done_o[1]));
    uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .tx_start(start[2]),
        .tx_data(data[2]), .tx(tx_o[2]), .tx_busy(busy_o[2]), .tx_done(done_o[2]));
    uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut3 (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .tx_start(start[3]),
        .tx_data(data[3]), .tx(tx_o[3]), .tx_busy(busy_o[3]), .tx_done(done_o[3]));

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            tick_div = tick_div + 2'd1;
            sample_tick = (tick_div == 2'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    // Accept one word, check the start-bit latency, then every clk of the frame and the done pulse
    task automatic send_frame(input int sel, input logic [7:0] d, input logic [11:0] frame,
                              input int nbits, input bit hold, input bit poke);
        bit fell;
        bit ts;
        @(negedge clk);
        start[sel] = 1'b1;
        data[sel]  = d;
        @(posedge clk);
        #1;
        check($sformatf("busy_after_accept dut%0d", sel), busy_o[sel], 1'b1);
        @(negedge clk);
        if (!hold) start[sel] = 1'b0;
        fell = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            ts = sample_tick;
            #1;
            if (ts) begin
                check($sformatf("start_edge dut%0d", sel), tx_o[sel], 1'b0);
                fell = 1'b1;
                break;
            end else begin
                check($sformatf("sync_tx dut%0d", sel), tx_o[sel], 1'b1);
                check($sformatf("sync_busy dut%0d", sel), busy_o[sel], 1'b1);
                check($sformatf("sync_done dut%0d", sel), done_o[sel], 1'b0);
            end
        end
        if (!fell) check($sformatf("start_timeout dut%0d", sel), 1'b0, 1'b1);
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < 4; c++) begin
                if (i != 0 || c != 0) begin
                    @(posedge clk);
                    #1;
                end
                if (poke && i == 3 && c == 1) begin
                    start[sel] = 1'b1;
                    data[sel]  = 8'hFF;
                end
                if (poke && i == 3 && c == 2) start[sel] = 1'b0;
                check($sformatf("bit%0d clk%0d tx dut%0d", i, c, sel), tx_o[sel], frame[i]);
                check($sformatf("bit%0d clk%0d busy dut%0d", i, c, sel), busy_o[sel], 1'b1);
                check($sformatf("bit%0d clk%0d done dut%0d", i, c, sel), done_o[sel], 1'b0);
            end
        end
        @(posedge clk);
        #1;
        check($sformatf("done_pulse dut%0d", sel), done_o[sel], 1'b1);
        check($sformatf("done_busy dut%0d", sel), busy_o[sel], 1'b0);
        check($sformatf("done_tx dut%0d", sel), tx_o[sel], 1'b1);
    endtask

    task automatic check_idle(input int sel, input int cycles, input string tag);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s tx dut%0d clk%0d", tag, sel, k), tx_o[sel], 1'b1);
            check($sformatf("%s busy dut%0d clk%0d", tag, sel, k), busy_o[sel], 1'b0);
            check($sformatf("%s done dut%0d clk%0d", tag, sel, k), done_o[sel], 1'b0);
        end
    endtask

    initial begin
        bit ts;
        bit fell;
        for (int s = 0; s < 4; s++) data[s] = 8'h00;

        //            sel  data    {pad, stop(s)/parity, data[7:0], start}        nbits poke
        vecs[0] = '{0, 8'hA5, 12'b00_1_10100101_0,  10, 1'b0};
        vecs[1] = '{1, 8'hA5, 12'b0_1_0_10100101_0, 11, 1'b0};
        vecs[2] = '{2, 8'hA5, 12'b0_1_1_10100101_0, 11, 1'b0};
        vecs[3] = '{1, 8'h01, 12'b0_1_1_00000001_0, 11, 1'b0};
        vecs[4] = '{3, 8'h00, 12'b0_11_00000000_0,  11, 1'b1};
        vecs[5] = '{0, 8'h3C, 12'b00_1_00111100_0,  10, 1'b0};
        vecs[6] = '{1, 8'hFF, 12'b0_1_0_11111111_0, 11, 1'b0};
        vecs[7] = '{2, 8'h00, 12'b0_1_1_00000000_0, 11, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            check($sformatf("reset tx dut%0d", s), tx_o[s], 1'b1);
            check($sformatf("reset busy dut%0d", s), busy_o[s], 1'b0);
            check($sformatf("reset done dut%0d", s), done_o[s], 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            send_frame(vecs[v].sel, vecs[v].data, vecs[v].frame, vecs[v].nbits, 1'b0, vecs[v].poke);
            check_idle(vecs[v].sel, vecs[v].poke ? 16 : 2, $sformatf("post_frame%0d", v));
        end

        // Back-to-back: tx_start held high across tx_done
        send_frame(0, 8'h55, 12'b00_1_01010101_0, 10, 1'b1, 1'b0);
        send_frame(0, 8'hAA, 12'b00_1_10101010_0, 10, 1'b0, 1'b0);
        check_idle(0, 8, "after_b2b");

        // Reset during data bit 3 of 8'hF0, then a clean 8'h3C
        @(negedge clk);
        start[0] = 1'b1;
        data[0]  = 8'hF0;
        @(negedge clk);
        start[0] = 1'b0;
        fell = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            ts = sample_tick;
            #1;
            if (ts) begin
                fell = 1'b1;
                break;
            end
        end
        if (!fell) check("rst_test_start_timeout", 1'b0, 1'b1);
        repeat (17) @(posedge clk);
        #1;
        check("rst_pre_bit3_tx", tx_o[0], 1'b0);
        check("rst_pre_busy", busy_o[0], 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midframe_rst tx", tx_o[0], 1'b1);
        check("midframe_rst busy", busy_o[0], 1'b0);
        check("midframe_rst done", done_o[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        check_idle(0, 8, "after_rst");
        send_frame(0, 8'h3C, 12'b00_1_00111100_0, 10, 1'b0, 1'b0);

        // Idle line over 100 tick periods
        check_idle(0, 400, "idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
